// File: rtl/ifetch_prefetch_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_prefetch_buffer_if
//  Brief    : Bundles the memory-fetch, core-delivery and redirect signals of
//             the instruction prefetch buffer. The master side is the fetch
//             unit; the slave side is the memory/core environment.
//  Revision : 1.0  initial release
// ============================================================================
interface ifetch_prefetch_buffer_if;
  // Instruction memory request channel
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  // Instruction memory response channel (in order, one per accepted request)
  logic        rsp_valid;
  logic [31:0] rsp_data;
  // Delivery channel towards the core
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  // Control-flow redirect from the core
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    output out_valid,
    output out_pc,
    output out_instr,
    input  out_ready,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    input  out_valid,
    input  out_pc,
    input  out_instr,
    output out_ready,
    output redirect_valid,
    output redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/ifetch_prefetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_prefetch_buffer
//  Brief    : Sequential instruction prefetcher. Issues word fetches to an
//             in-order variable-latency memory, queues {pc, instr} pairs in a
//             DEPTH-entry FIFO and hands them to the core over valid/ready.
//             A redirect clears the queue, drains in-flight responses and
//             restarts fetch at the new PC.
//  Options  : IFB_STATS_EN - adds saturating flush / stall counters.
//  Revision : 1.0  initial release
// ============================================================================
module ifetch_prefetch_buffer #(
  parameter int          DEPTH    = 4,             // power of two, >= 2
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ifetch_prefetch_buffer_if.master  bus
`ifdef IFB_STATS_EN
  ,
  output logic [31:0]               stat_flush_cnt,
  output logic [31:0]               stat_stall_cnt
`endif
);

  // Pointer width and counter width (counters must reach DEPTH itself).
  localparam int c_pw = $clog2(DEPTH);
  localparam int c_cw = c_pw + 1;
  localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t            r_state;
  logic [31:0]       r_fetch_pc;
  logic [c_pw-1:0]   r_wr_ptr;
  logic [c_pw-1:0]   r_rd_ptr;
  logic [c_cw-1:0]   r_count;
  logic [c_cw-1:0]   r_outstanding;
  logic [c_cw-1:0]   r_discard;
  logic [31:0]       r_pc_mem    [DEPTH];
  logic [31:0]       r_instr_mem [DEPTH];

  // --------------------------------------------------------------------------
  // Next-state values
  // --------------------------------------------------------------------------
  state_t            w_state_nxt;
  logic [31:0]       w_fetch_pc_nxt;
  logic [c_pw-1:0]   w_wr_ptr_nxt;
  logic [c_pw-1:0]   w_rd_ptr_nxt;
  logic [c_cw-1:0]   w_count_nxt;
  logic [c_cw-1:0]   w_outstanding_nxt;
  logic [c_cw-1:0]   w_discard_nxt;
  logic              w_push;

  // --------------------------------------------------------------------------
  // Handshake qualifiers
  // --------------------------------------------------------------------------
  logic              w_credit;
  logic              w_req_valid;
  logic              w_req_fire;
  logic              w_rsp;
  logic              w_out_valid;
  logic              w_pop;
  logic [31:0]       w_rsp_pc;
  logic [31:0]       w_redirect_pc;
  logic              w_unused;

  // Queued plus in-flight entries never exceed DEPTH, so a returning
  // response always has a free FIFO slot.
  assign w_credit    = (r_count + r_outstanding) < c_depth;
  // Gating with rst_n keeps the request low while reset is held.
  assign w_req_valid = rst_n && (r_state == ST_RUN) && w_credit;
  assign w_req_fire  = w_req_valid && bus.req_ready;
  // A response with nothing outstanding is a protocol violation; ignore it.
  assign w_rsp       = bus.rsp_valid && (r_outstanding != '0);
  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid && bus.out_ready;

  // The oldest outstanding request was issued 4*outstanding bytes before
  // the current fetch address; this avoids storing a PC per in-flight slot.
  assign w_rsp_pc      = r_fetch_pc - {{(30 - c_cw){1'b0}}, r_outstanding, 2'b00};
  assign w_redirect_pc = {bus.redirect_pc[31:2], 2'b00};
  assign w_unused      = &{1'b0, bus.redirect_pc[1:0]};

  // Next-state and datapath control for the RUN/FLUSH machine.
  always_comb begin
    w_state_nxt       = r_state;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_wr_ptr_nxt      = r_wr_ptr;
    w_rd_ptr_nxt      = r_rd_ptr;
    w_count_nxt       = r_count;
    w_outstanding_nxt = r_outstanding;
    w_discard_nxt     = r_discard;
    w_push            = 1'b0;

    if (w_req_fire) begin
      w_fetch_pc_nxt = r_fetch_pc + 32'd4;
    end

    case ({w_req_fire, w_rsp})
      2'b10:   w_outstanding_nxt = r_outstanding + c_cw'(1);
      2'b01:   w_outstanding_nxt = r_outstanding - c_cw'(1);
      default: w_outstanding_nxt = r_outstanding;
    endcase

    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + c_pw'(1);
    end

    case (r_state)
      ST_RUN: begin
        if (w_rsp) begin
          w_push       = 1'b1;
          w_wr_ptr_nxt = r_wr_ptr + c_pw'(1);
        end
      end
      ST_FLUSH: begin
        // Stale responses are dropped until every pre-redirect fetch returns.
        if (w_rsp) begin
          w_discard_nxt = r_discard - c_cw'(1);
        end
        if (w_discard_nxt == '0) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase

    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_cw'(1);
      2'b01:   w_count_nxt = r_count - c_cw'(1);
      default: w_count_nxt = r_count;
    endcase

    // Redirect overrides everything: clear the queue, drop this cycle's
    // response and wait out every fetch still in flight (including one
    // accepted this very cycle at the old address).
    if (bus.redirect_valid) begin
      w_push         = 1'b0;
      w_fetch_pc_nxt = w_redirect_pc;
      w_wr_ptr_nxt   = '0;
      w_rd_ptr_nxt   = '0;
      w_count_nxt    = '0;
      w_discard_nxt  = w_outstanding_nxt;
      w_state_nxt    = (w_outstanding_nxt != '0) ? ST_FLUSH : ST_RUN;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch address, queue pointers and occupancy/in-flight counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_count       <= w_count_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_discard     <= w_discard_nxt;
    end
  end

  // FIFO storage; contents are only observed while the entry is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= w_rsp_pc;
      r_instr_mem[r_wr_ptr] <= bus.rsp_data;
    end
  end

  assign bus.req_valid = w_req_valid;
  assign bus.req_addr  = r_fetch_pc;
  assign bus.out_valid = w_out_valid;
  assign bus.out_pc    = w_out_valid ? r_pc_mem[r_rd_ptr]    : 32'h0;
  assign bus.out_instr = w_out_valid ? r_instr_mem[r_rd_ptr] : 32'h0;

`ifdef IFB_STATS_EN
  logic [31:0] r_flush_cnt;
  logic [31:0] r_stall_cnt;

  // Saturating event counters: redirects seen, and cycles the core starved
  // outside of a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (bus.redirect_valid && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
      if (!w_out_valid && (r_state != ST_FLUSH) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign stat_flush_cnt = r_flush_cnt;
  assign stat_stall_cnt = r_stall_cnt;
`endif

`ifndef SYNTHESIS
  // Memory must never return more responses than requests it accepted.
  a_rsp_without_request: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(bus.rsp_valid && (r_outstanding == '0))
  ) else $error("ifetch_prefetch_buffer: rsp_valid with no outstanding request");
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_prefetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifetch_prefetch_buffer
//  Brief    : Directed self-checking bench for ifetch_prefetch_buffer with a
//             fixed-latency in-order instruction memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ifetch_prefetch_buffer;

  logic clk;
  logic rst_n;

  ifetch_prefetch_buffer_if bus();

`ifdef IFB_STATS_EN
  logic [31:0] stat_flush_cnt;
  logic [31:0] stat_stall_cnt;
`endif

  ifetch_prefetch_buffer #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus)
`ifdef IFB_STATS_EN
    ,
    .stat_flush_cnt (stat_flush_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int mem_lat  = 1;

  // Instruction word stored at each address.
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          ready;
  } mreq_t;

  mreq_t mq[$];
  int    mcyc = 0;

  initial begin
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.req_valid && bus.req_ready) begin
        mq.push_back('{addr: bus.req_addr, ready: mcyc + mem_lat});
      end
      @(posedge clk);
      #1;
      mcyc++;
      if (!rst_n) begin
        mq.delete();
        bus.rsp_valid = 1'b0;
      end else if (mq.size() > 0 && mq[0].ready <= mcyc) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = instr_at(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        bus.rsp_valid = 1'b0;
      end
    end
  end

  // ---------------- delivery / traffic monitor ----------------
  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];
  int          n_fire  = 0;
  int          mdl_out = 0;
  int          max_out = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        got_pc.delete();
        got_instr.delete();
        n_fire  = 0;
        mdl_out = 0;
        max_out = 0;
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          got_pc.push_back(bus.out_pc);
          got_instr.push_back(bus.out_instr);
        end
        if (bus.req_valid && bus.req_ready) begin
          n_fire++;
          mdl_out++;
        end
        if (bus.rsp_valid) mdl_out--;
        if (mdl_out > max_out) max_out = mdl_out;
      end
    end
  end

  function automatic logic [31:0] got_pc_at(input int i);
    return (i < got_pc.size()) ? got_pc[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] got_instr_at(input int i);
    return (i < got_instr.size()) ? got_instr[i] : 32'hDEAD_BEEF;
  endfunction

  // Hold reset for two cycles, then release at posedge+1 ("cycle 1").
  task automatic do_reset(input int lat, input logic rdy_out, input logic rdy_req);
    rst_n              = 1'b0;
    mem_lat            = lat;
    bus.out_ready      = rdy_out;
    bus.req_ready      = rdy_req;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.req_ready      = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // ---- 1: streaming, 1-cycle memory ----
    rst_n = 1'b0;
    mem_lat = 1;
    bus.out_ready = 1'b1;
    bus.req_ready = 1'b1;
    tick();
    tick();
    check_val("rst_req_valid", 32'(bus.req_valid), 32'd0);
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_out_pc",    bus.out_pc,         32'h0);
    check_val("rst_out_instr", bus.out_instr,      32'h0);
    rst_n = 1'b1;
    #1;
    check_val("t1_req_valid0", 32'(bus.req_valid), 32'd1);
    check_val("t1_req_addr0",  bus.req_addr,       32'h0);
    tick();
    check_val("t1_no_bypass",  32'(bus.out_valid), 32'd0);
    check_val("t1_req_addr1",  bus.req_addr,       32'h4);
    tick();
    check_val("t1_first_valid", 32'(bus.out_valid), 32'd1);
    check_val("t1_first_pc",    bus.out_pc,         32'h0);
    check_val("t1_first_instr", bus.out_instr,      instr_at(32'h0));
    repeat (10) tick();
    check_val("t1_ndeliv_ge8", 32'(got_pc.size() >= 8), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("t1_pc%0d", i),    got_pc_at(i),    32'(4 * i));
      check_val($sformatf("t1_instr%0d", i), got_instr_at(i), instr_at(32'(4 * i)));
    end
`ifdef IFB_STATS_EN
    check_val("t1_stall_cnt", stat_stall_cnt, 32'd2);
    check_val("t1_flush_cnt", stat_flush_cnt, 32'd0);
`endif

    // ---- 2: back-pressure fills the queue ----
    do_reset(1, 1'b0, 1'b1);
    repeat (10) tick();
    check_val("t2_nfire",       32'(n_fire),         32'd4);
    check_val("t2_req_stopped", 32'(bus.req_valid),  32'd0);
    check_val("t2_out_valid",   32'(bus.out_valid),  32'd1);
    check_val("t2_head_pc",     bus.out_pc,          32'h0);
    bus.out_ready = 1'b1;
    #1;
    check_val("t2_req_before_pop", 32'(bus.req_valid), 32'd0);
    tick();
    check_val("t2_req_resume", 32'(bus.req_valid), 32'd1);
    check_val("t2_req_addr",   bus.req_addr,       32'h10);
    repeat (12) tick();
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("t2_pc%0d", i), got_pc_at(i), 32'(4 * i));
    end

    // ---- 3: 5-cycle memory, credit limit ----
    do_reset(5, 1'b1, 1'b1);
    repeat (60) tick();
    check_val("t3_max_outstanding", 32'(max_out), 32'd4);
    check_val("t3_ndeliv_ge20", 32'(got_pc.size() >= 20), 32'd1);
    begin
      int bad = 0;
      for (int i = 0; i < got_pc.size(); i++) begin
        if (got_pc[i] !== 32'(4 * i) || got_instr[i] !== instr_at(32'(4 * i))) bad++;
      end
      check_val("t3_seq_gaps", 32'(bad), 32'd0);
    end
    rst_n = 1'b0;
    #1;
    check_val("t3_midrst_req", 32'(bus.req_valid), 32'd0);
    check_val("t3_midrst_out", 32'(bus.out_valid), 32'd0);

    // ---- 4: redirect with 3 fetches in flight ----
    do_reset(5, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    bus.req_ready      = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    check_val("t4_inflight", 32'(n_fire), 32'd3);
    tick();
    bus.redirect_valid = 1'b0;
    bus.req_ready      = 1'b1;
    check_val("t4_flush_req", 32'(bus.req_valid), 32'd0);
    check_val("t4_flush_out", 32'(bus.out_valid), 32'd0);
    tick();
    tick();
    tick();
    check_val("t4_flush_hold", 32'(bus.req_valid), 32'd0);
    tick();
    check_val("t4_restart_req",  32'(bus.req_valid), 32'd1);
    check_val("t4_restart_addr", bus.req_addr,       32'h100);
    check_val("t4_none_leaked",  32'(got_pc.size()), 32'd0);
    repeat (14) tick();
    check_val("t4_first_pc",    got_pc_at(0),    32'h100);
    check_val("t4_first_instr", got_instr_at(0), instr_at(32'h100));
    check_val("t4_second_pc",   got_pc_at(1),    32'h104);
`ifdef IFB_STATS_EN
    check_val("t4_flush_cnt", stat_flush_cnt, 32'd1);
`endif

    // ---- 5: back-to-back redirects, last wins ----
    do_reset(1, 1'b1, 1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    #1;
    check_val("t5_old_req_valid", 32'(bus.req_valid), 32'd1);
    check_val("t5_old_req_addr",  bus.req_addr,       32'h0);
    tick();
    bus.redirect_pc = 32'h80;
    check_val("t5_flush_req", 32'(bus.req_valid), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    check_val("t5_run_req",  32'(bus.req_valid), 32'd1);
    check_val("t5_run_addr", bus.req_addr,       32'h80);
    repeat (8) tick();
    check_val("t5_first_pc",    got_pc_at(0),    32'h80);
    check_val("t5_first_instr", got_instr_at(0), instr_at(32'h80));
`ifdef IFB_STATS_EN
    check_val("t5_flush_cnt", stat_flush_cnt, 32'd2);
`endif

    // ---- 6: address wrap at the top of memory ----
    do_reset(1, 1'b1, 1'b0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFB;
    tick();
    bus.redirect_valid = 1'b0;
    bus.req_ready      = 1'b1;
    check_val("t6_addr0", bus.req_addr, 32'hFFFF_FFF8);
    tick();
    check_val("t6_addr1", bus.req_addr, 32'hFFFF_FFFC);
    tick();
    check_val("t6_addr2", bus.req_addr, 32'h0000_0000);
    repeat (8) tick();
    check_val("t6_pc0", got_pc_at(0), 32'hFFFF_FFF8);
    check_val("t6_pc1", got_pc_at(1), 32'hFFFF_FFFC);
    check_val("t6_pc2", got_pc_at(2), 32'h0000_0000);
    check_val("t6_pc3", got_pc_at(3), 32'h0000_0004);
    check_val("t6_instr1", got_instr_at(1), instr_at(32'hFFFF_FFFC));
`ifdef IFB_STATS_EN
    check_val("t6_flush_cnt", stat_flush_cnt, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
